// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared types and helpers for the SDRAM port1 arbiter.
//   - arb_state_t : arbiter FSM states
//   - arb_req_t   : one byte-wide request (address, write flag, write data)
//   - ds_for()    : byte-lane select for a request
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,   // realign sd_req with sd_ack
        IDLE = 2'd1,   // choose the next requester
        CPU  = 2'd2,   // CPU request outstanding
        LD   = 2'd3    // loader request outstanding
    } arb_state_t;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [7:0]  d;
    } arb_req_t;

    // Reads fetch the whole word; writes touch only the addressed byte lane.
    function automatic logic [1:0] ds_for(input logic we, input logic a0);
        return we ? (a0 ? 2'b10 : 2'b01) : 2'b11;
    endfunction

endpackage

// File: rtl/sdram_cpu_evt.sv
// -----------------------------------------------------------------------------
// sdram_cpu_evt
//   Turns the Oric CPU/ULA RAM strobes into discrete SDRAM requests.
//   Ports:
//     clk, res_n        : clock, async active-low reset
//     cpu_cs/oe/we/a/d  : raw CPU bus
//     take              : arbiter consumed the request presented this clock
//     cpu_vld           : a CPU request is available (pending or arriving now)
//     cpu_req           : the request to issue (arriving event beats the
//                         held one, so the newest access always wins)
// -----------------------------------------------------------------------------
module sdram_cpu_evt
    import sdram_arb_pkg::*;
#(
    parameter logic [1:0] ROM_HI = 2'b11
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        cpu_cs,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        take,
    output logic        cpu_vld,
    output arb_req_t    cpu_req
);

    logic        rd, wr;
    logic        rd_h, wr_h;
    logic [15:0] a_h;
    logic        evt, qual;
    logic        pend;
    arb_req_t    hold, live;

    assign rd   = cpu_cs & cpu_oe;
    assign wr   = cpu_cs & cpu_we;

    // A read that stays asserted while the address moves is a new access.
    assign evt  = (rd & ~rd_h) | (wr & ~wr_h) | (rd & (cpu_a != a_h));
    assign qual = evt & (cpu_a[15:14] != ROM_HI);

    assign live    = '{a: cpu_a, we: cpu_we, d: cpu_d};
    assign cpu_vld = pend | qual;
    assign cpu_req = qual ? live : hold;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rd_h <= 1'b0;
            wr_h <= 1'b0;
            a_h  <= '0;
            pend <= 1'b0;
            hold <= '0;
        end else begin
            rd_h <= rd;
            wr_h <= wr;
            a_h  <= cpu_a;
            // take consumes whatever cpu_req showed, including a live event,
            // so clearing pend here never drops an access.
            if (take) begin
                pend <= 1'b0;
            end else if (qual) begin
                pend <= 1'b1;
                hold <= live;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_port_arb
//   Shares the SDRAM port1 toggle handshake between the Oric CPU bus and the
//   DSK/TAP block loader. CPU has fixed priority; one request in flight.
//   Ports:
//     clk, res_n                 : 72 MHz SDRAM clock, async active-low reset
//     cpu_cs/oe/we/a/d, cpu_q    : CPU bus in, latched read data out
//     ld_req/we/a/d, ld_q, ld_ack: loader level request, data + ack pulse
//     sd_req/ack/a/we/ds/d/q     : SDRAM port1 toggle interface
//     busy                       : a request is outstanding
//     err                        : sticky watchdog abort
// -----------------------------------------------------------------------------
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int         TIMEOUT = 32,
    parameter logic [1:0] ROM_HI  = 2'b11
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        cpu_cs,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_a,
    input  logic [7:0]  ld_d,
    output logic [7:0]  ld_q,
    output logic        ld_ack,
    output logic        sd_req,
    input  logic        sd_ack,
    output logic [15:0] sd_a,
    output logic        sd_we,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_d,
    input  logic [15:0] sd_q,
    output logic        busy,
    output logic        err
);

    localparam int              WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_INIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(1);

    arb_state_t     state;
    logic [WDW-1:0] wdog;
    logic           cpu_vld, cpu_take, acked;
    arb_req_t       cpu_rq, ld_rq, nxt;
    logic [7:0]     rd_byte;

    sdram_cpu_evt #(.ROM_HI(ROM_HI)) u_evt (
        .clk     (clk),
        .res_n   (res_n),
        .cpu_cs  (cpu_cs),
        .cpu_oe  (cpu_oe),
        .cpu_we  (cpu_we),
        .cpu_a   (cpu_a),
        .cpu_d   (cpu_d),
        .take    (cpu_take),
        .cpu_vld (cpu_vld),
        .cpu_req (cpu_rq)
    );

    assign cpu_take = (state == IDLE) && cpu_vld;
    assign ld_rq    = '{a: ld_a, we: ld_we, d: ld_d};
    assign nxt      = cpu_vld ? cpu_rq : ld_rq;
    assign acked    = (sd_ack == sd_req);
    assign rd_byte  = sd_a[0] ? sd_q[15:8] : sd_q[7:0];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state  <= SYNC;
            wdog   <= '0;
            cpu_q  <= '0;
            ld_q   <= '0;
            ld_ack <= 1'b0;
            sd_req <= 1'b0;
            sd_a   <= '0;
            sd_we  <= 1'b0;
            sd_ds  <= 2'b11;
            sd_d   <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ld_ack <= 1'b0;
            case (state)
                // Adopt whatever toggle phase the SDRAM side holds so a
                // stale unmatched toggle is never mistaken for our request.
                SYNC: begin
                    sd_req <= sd_ack;
                    state  <= IDLE;
                end
                IDLE: begin
                    if (cpu_vld || ld_req) begin
                        sd_a   <= nxt.a;
                        sd_we  <= nxt.we;
                        sd_ds  <= ds_for(nxt.we, nxt.a[0]);
                        sd_d   <= {nxt.d, nxt.d};
                        sd_req <= ~sd_req;
                        wdog   <= WD_INIT;
                        busy   <= 1'b1;
                        state  <= cpu_vld ? CPU : LD;
                    end
                end
                CPU, LD: begin
                    if (acked) begin
                        if (!sd_we) begin
                            if (state == CPU) cpu_q <= rd_byte;
                            else              ld_q  <= rd_byte;
                        end
                        if (state == LD) ld_ack <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wdog <= WD_LAST) begin
                        // Abort: the loader still gets its ack so it cannot
                        // hang waiting, but with zeroed data.
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= SYNC;
                        wdog  <= '0;
                        if (state == LD) begin
                            ld_ack <= 1'b1;
                            ld_q   <= '0;
                        end
                    end else begin
                        wdog <= wdog - WD_LAST;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arb
//   Bench for sdram_port_arb: a behavioural SDRAM responder with its own
//   memory, plus a byte-level reference memory holding what each address
//   should contain after the accesses the bench has made.
// -----------------------------------------------------------------------------
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        res_n;
    logic        cpu_cs, cpu_oe, cpu_we;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d, cpu_q;
    logic        ld_req, ld_we, ld_ack;
    logic [15:0] ld_a;
    logic [7:0]  ld_d, ld_q;
    logic        sd_req, sd_ack, sd_we, busy, err;
    logic [15:0] sd_a, sd_d, sd_q;
    logic [1:0]  sd_ds;

    sdram_port_arb dut (
        .clk(clk), .res_n(res_n),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_a(cpu_a),
        .cpu_d(cpu_d), .cpu_q(cpu_q),
        .ld_req(ld_req), .ld_we(ld_we), .ld_a(ld_a), .ld_d(ld_d),
        .ld_q(ld_q), .ld_ack(ld_ack),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_a(sd_a), .sd_we(sd_we),
        .sd_ds(sd_ds), .sd_d(sd_d), .sd_q(sd_q),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        we;
        logic [1:0]  ds;
        logic [15:0] d;
        int          c;
    } log_t;

    log_t        log_q[$];
    logic [7:0]  sd_mem [0:65535];
    logic [7:0]  ref_mem[0:65535];
    int          tests = 0, fails = 0;
    int          cyc = 0, last_ack_cyc = 0, fall_cyc = 0;
    int          lat_cfg = -1;
    bit          resp_en = 0, noack = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SDRAM port1 responder: logs each new toggle, acks after a latency.
    initial begin : responder
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            sd_q = 16'($urandom);
            if (!resp_en || sd_req == sd_ack) begin
                cnt = -1;
            end else if (cnt < 0) begin
                log_q.push_back('{a: sd_a, we: sd_we, ds: sd_ds, d: sd_d, c: cyc});
                cnt = (lat_cfg < 0) ? int'($urandom_range(0, 4)) : lat_cfg;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (cnt == 0 && !noack) begin
                if (sd_we) begin
                    if (sd_ds[0]) sd_mem[{sd_a[15:1], 1'b0}] = sd_d[7:0];
                    if (sd_ds[1]) sd_mem[{sd_a[15:1], 1'b1}] = sd_d[15:8];
                end else begin
                    sd_q = {sd_mem[{sd_a[15:1], 1'b1}], sd_mem[{sd_a[15:1], 1'b0}]};
                end
                sd_ack       = sd_req;
                last_ack_cyc = cyc;
                cnt          = -1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // Waits until the arbiter is idle for two consecutive samples (a pending
    // CPU request would re-raise busy in between).
    task automatic wait_idle(output bit ok);
        int z;
        z = 0; ok = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                if (z == 0) fall_cyc = cyc;
                z++;
                if (z == 2) begin ok = 1; break; end
            end else begin
                z = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic we, input logic [7:0] d,
                          output bit ok);
        cpu_a = a; cpu_we = we; cpu_d = d; cpu_cs = 1'b1; cpu_oe = ~we;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
        wait_idle(ok);
    endtask

    task automatic ld_op(input logic [15:0] a, input logic we, input logic [7:0] d,
                         output logic [7:0] q, output int ack_c, output bit ok);
        ld_a = a; ld_we = we; ld_d = d; ld_req = 1'b1; ok = 0; q = 'x; ack_c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ld_ack) begin q = ld_q; ack_c = cyc; ok = 1; break; end
        end
        ld_req = 1'b0;
    endtask

    task automatic test_reset;
        res_n = 1'b0; sd_ack = 1'b1; resp_en = 0;
        cpu_cs = 0; cpu_oe = 0; cpu_we = 0; cpu_a = '0; cpu_d = '0;
        ld_req = 0; ld_we = 0; ld_a = '0; ld_d = '0;
        repeat (3) @(negedge clk);
        tests++; if (sd_req !== 1'b0) begin fails++; $display("FAIL rst_sd_req: got %b want 0", sd_req); end
        tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rst_busy_err: got %b%b want 00", busy, err); end
        tests++; if (sd_ds !== 2'b11 || sd_a !== 16'h0 || sd_d !== 16'h0 || sd_we !== 1'b0)
            begin fails++; $display("FAIL rst_sd_bus: got ds=%b a=%h d=%h we=%b want 11/0/0/0", sd_ds, sd_a, sd_d, sd_we); end
        tests++; if (cpu_q !== 8'h0 || ld_q !== 8'h0 || ld_ack !== 1'b0)
            begin fails++; $display("FAIL rst_data: got cpu_q=%h ld_q=%h ld_ack=%b want 0", cpu_q, ld_q, ld_ack); end
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (sd_req !== 1'b1) begin fails++; $display("FAIL sync_sd_req: got %b want 1", sd_req); end
        resp_en = 1;
        repeat (6) @(negedge clk);
        tests++; if (log_q.size() != 0 || sd_req !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL sync_no_req: got reqs=%0d sd_req=%b busy=%b want 0/1/0", log_q.size(), sd_req, busy); end
    endtask

    task automatic test_cpu_read;
        int n; bit ok;
        sd_mem[16'h1234] = 8'h12; sd_mem[16'h1235] = 8'hAB;
        ref_mem[16'h1234] = 8'h12; ref_mem[16'h1235] = 8'hAB;
        lat_cfg = 5; n = log_q.size();
        cpu_op(16'h1235, 1'b0, 8'h00, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rd_done: got busy stuck want idle"); end
        tests++; if (log_q.size() != n + 1) begin fails++; $display("FAIL rd_toggles: got %0d want 1", log_q.size() - n); end
        else begin
            tests++; if (log_q[n].a !== 16'h1235 || log_q[n].we !== 1'b0 || log_q[n].ds !== 2'b11)
                begin fails++; $display("FAIL rd_req: got a=%h we=%b ds=%b want 1235/0/11", log_q[n].a, log_q[n].we, log_q[n].ds); end
        end
        tests++; if (cpu_q !== 8'hAB) begin fails++; $display("FAIL rd_cpu_q: got %h want ab", cpu_q); end
        tests++; if (fall_cyc - last_ack_cyc != 1)
            begin fails++; $display("FAIL rd_busy_fall: got %0d clocks after ack want 1", fall_cyc - last_ack_cyc); end
    endtask

    task automatic test_cpu_write;
        int n; bit ok;
        lat_cfg = 2; n = log_q.size();
        cpu_op(16'h0400, 1'b1, 8'h5A, ok);
        ref_mem[16'h0400] = 8'h5A;
        tests++; if (!ok || log_q.size() != n + 1) begin fails++; $display("FAIL wr_issue: got %0d reqs want 1", log_q.size() - n); end
        else begin
            tests++; if (log_q[n].we !== 1'b1 || log_q[n].ds !== 2'b01 || log_q[n].d !== 16'h5A5A || log_q[n].a !== 16'h0400)
                begin fails++; $display("FAIL wr_req: got we=%b ds=%b d=%h a=%h want 1/01/5a5a/0400", log_q[n].we, log_q[n].ds, log_q[n].d, log_q[n].a); end
        end
        n = log_q.size();
        cpu_op(16'hC000, 1'b1, 8'h77, ok);
        cpu_op(16'hC123, 1'b0, 8'h00, ok);
        repeat (4) @(negedge clk);
        tests++; if (log_q.size() != n) begin fails++; $display("FAIL rom_skip: got %0d reqs want 0", log_q.size() - n); end
        cpu_op(16'h0400, 1'b0, 8'h00, ok);
        tests++; if (cpu_q !== 8'h5A) begin fails++; $display("FAIL wr_readback: got %h want 5a", cpu_q); end
    endtask

    task automatic test_addr_change;
        int n; bit ok;
        lat_cfg = 4; n = log_q.size();
        cpu_a = 16'h0100; cpu_we = 0; cpu_cs = 1; cpu_oe = 1;
        @(negedge clk);
        cpu_a = 16'h0203;
        @(negedge clk);
        cpu_cs = 0; cpu_oe = 0;
        wait_idle(ok);
        tests++; if (log_q.size() != n + 2) begin fails++; $display("FAIL achg_count: got %0d reqs want 2", log_q.size() - n); end
        else begin
            tests++; if (log_q[n].a !== 16'h0100 || log_q[n+1].a !== 16'h0203)
                begin fails++; $display("FAIL achg_order: got %h,%h want 0100,0203", log_q[n].a, log_q[n+1].a); end
        end
        tests++; if (cpu_q !== ref_mem[16'h0203]) begin fails++; $display("FAIL achg_q: got %h want %h", cpu_q, ref_mem[16'h0203]); end
    endtask

    task automatic test_ld_then_cpu;
        int n, ackc; bit ok, ok2; logic [7:0] q;
        sd_mem[16'h2000] = 8'h3C; ref_mem[16'h2000] = 8'h3C;
        lat_cfg = 6; n = log_q.size();
        fork
            ld_op(16'h2000, 1'b0, 8'h00, q, ackc, ok);
            begin
                repeat (2) @(negedge clk);
                cpu_a = 16'h0345; cpu_we = 0; cpu_cs = 1; cpu_oe = 1;
                @(negedge clk);
                cpu_cs = 0; cpu_oe = 0;
            end
        join
        @(negedge clk);
        tests++; if (ld_ack !== 1'b0) begin fails++; $display("FAIL ld_ack_pulse: got %b want 0", ld_ack); end
        wait_idle(ok2);
        tests++; if (!ok || q !== 8'h3C) begin fails++; $display("FAIL ld_q: got %h want 3c", q); end
        tests++; if (log_q.size() != n + 2) begin fails++; $display("FAIL ldcpu_count: got %0d want 2", log_q.size() - n); end
        else begin
            tests++; if (log_q[n].a !== 16'h2000 || log_q[n+1].a !== 16'h0345)
                begin fails++; $display("FAIL ldcpu_order: got %h,%h want 2000,0345", log_q[n].a, log_q[n+1].a); end
            tests++; if (log_q[n+1].c - ackc != 1)
                begin fails++; $display("FAIL ldcpu_gap: got %0d want 1", log_q[n+1].c - ackc); end
        end
        tests++; if (cpu_q !== ref_mem[16'h0345]) begin fails++; $display("FAIL ldcpu_q: got %h want %h", cpu_q, ref_mem[16'h0345]); end
    endtask

    task automatic test_simultaneous;
        int n, ackc; bit ok, ok2; logic [7:0] q;
        lat_cfg = 3; n = log_q.size();
        fork
            ld_op(16'h2222, 1'b1, 8'hC7, q, ackc, ok);
            begin
                cpu_a = 16'h1111; cpu_we = 0; cpu_cs = 1; cpu_oe = 1;
                @(negedge clk);
                cpu_cs = 0; cpu_oe = 0;
            end
        join
        wait_idle(ok2);
        ref_mem[16'h2222] = 8'hC7;
        tests++; if (!ok || log_q.size() != n + 2) begin fails++; $display("FAIL sim_count: got %0d want 2", log_q.size() - n); end
        else begin
            tests++; if (log_q[n].a !== 16'h1111 || log_q[n+1].a !== 16'h2222 || log_q[n+1].ds !== 2'b01)
                begin fails++; $display("FAIL sim_order: got %h,%h ds=%b want 1111,2222 ds=01", log_q[n].a, log_q[n+1].a, log_q[n+1].ds); end
        end
        tests++; if (cpu_q !== ref_mem[16'h1111]) begin fails++; $display("FAIL sim_cpu_q: got %h want %h", cpu_q, ref_mem[16'h1111]); end
        cpu_op(16'h2222, 1'b0, 8'h00, ok);
        tests++; if (cpu_q !== 8'hC7) begin fails++; $display("FAIL sim_ld_wr: got %h want c7", cpu_q); end
    endtask

    task automatic test_random;
        int n; bit ok; logic [15:0] a; logic we; logic [7:0] d, prev;
        lat_cfg = -1;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 255)) | ((i % 6 == 5) ? 16'hC000 : 16'h0800);
            we = 1'($urandom);
            d = 8'($urandom);
            prev = cpu_q; n = log_q.size();
            cpu_op(a, we, d, ok);
            if (a[15:14] == 2'b11) begin
                tests++; if (log_q.size() != n || cpu_q !== prev)
                    begin fails++; $display("FAIL rnd_rom: a=%h got reqs=%0d q=%h want 0/%h", a, log_q.size() - n, cpu_q, prev); end
            end else if (we) begin
                ref_mem[a] = d;
                tests++; if (log_q.size() != n + 1 || log_q[n].ds !== (a[0] ? 2'd2 : 2'd1) || log_q[n].d !== {d, d} || cpu_q !== prev)
                    begin fails++; $display("FAIL rnd_wr: a=%h got reqs=%0d q=%h want 1 req q=%h", a, log_q.size() - n, cpu_q, prev); end
            end else begin
                tests++; if (!ok || cpu_q !== ref_mem[a])
                    begin fails++; $display("FAIL rnd_rd: a=%h got %h want %h", a, cpu_q, ref_mem[a]); end
            end
        end
    endtask

    task automatic test_timeout;
        int n, err_c, issue_c, ackc; bit ok; logic [7:0] q;
        noack = 1; n = log_q.size(); err_c = -1;
        cpu_a = 16'h3000; cpu_we = 0; cpu_cs = 1; cpu_oe = 1;
        @(negedge clk);
        cpu_cs = 0; cpu_oe = 0;
        for (int i = 0; i < 60; i++) begin
            if (err === 1'b1 && err_c < 0) err_c = cyc;
            @(negedge clk);
        end
        issue_c = (log_q.size() > n) ? log_q[n].c : -1000;
        tests++; if (err_c - issue_c != 32)
            begin fails++; $display("FAIL wd_time: got err after %0d clocks want 32", err_c - issue_c); end
        tests++; if (busy !== 1'b0 || sd_req !== sd_ack)
            begin fails++; $display("FAIL wd_sync: got busy=%b req=%b ack=%b want 0, req==ack", busy, sd_req, sd_ack); end
        ld_op(16'h2000, 1'b0, 8'h00, q, ackc, ok);
        tests++; if (!ok || q !== 8'h00) begin fails++; $display("FAIL wd_ld_abort: got ok=%b q=%h want 1/00", ok, q); end
        noack = 0;
        repeat (3) @(negedge clk);
        cpu_op(16'h3000, 1'b0, 8'h00, ok);
        tests++; if (!ok || cpu_q !== ref_mem[16'h3000])
            begin fails++; $display("FAIL wd_recover: got %h want %h", cpu_q, ref_mem[16'h3000]); end
        ld_op(16'h2000, 1'b0, 8'h00, q, ackc, ok);
        tests++; if (!ok || q !== 8'h3C) begin fails++; $display("FAIL wd_ld_recover: got %h want 3c", q); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b want 1", err); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sd_mem[i]  = 8'($urandom);
            ref_mem[i] = sd_mem[i];
        end
        sd_q = '0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_addr_change();
        test_ld_then_cpu();
        test_simultaneous();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
